dsu_stream: RTL and testbench
=============================

# dsu_stream

Parametrised multi-lane data streaming unit for the accelerator datapath. Accepts one descriptor (base, length, stride), reads LANES-wide words from a local buffer with one-cycle read latency, and streams them to the PE array over a valid/ready interface with full backpressure. Successor of the single-configuration DSU: it adds a configurable lane count, strided addressing, descriptor handshaking, a last-beat flag, a completion pulse and an abort.

## Interface
Parameters:
- DATA_W, 16: bits per lane element.
- LANES, 4: lanes per beat; beat width is LANES*DATA_W.
- ADDR_W, 10: buffer word-address width.
- LEN_W, 10: beat-count width.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- cfg_valid  in  1  descriptor valid.
- cfg_ready  out  1  descriptor accepted when high with cfg_valid; equals (state==IDLE).
- cfg_base  in  ADDR_W  first word address.
- cfg_len  in  LEN_W  number of beats; 0 is legal.
- cfg_stride  in  ADDR_W  address increment per beat.
- abort  in  1  synchronous flush to IDLE.
- mem_rd_en  out  1  buffer read strobe.
- mem_rd_addr  out  ADDR_W  buffer read address.
- mem_rd_data  in  LANES*DATA_W  read data, valid exactly one cycle after mem_rd_en.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream ready.
- out_data  out  LANES*DATA_W  beat payload; lane i is in bits [i*DATA_W +: DATA_W].
- out_last  out  1  high with the final beat of the descriptor.
- busy  out  1  descriptor in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN on cfg handshake with cfg_len>0.
  - IDLE -> IDLE on cfg handshake with cfg_len==0; done pulses the next cycle.
  - RUN -> DRAIN when the last read is issued.
  - DRAIN -> IDLE on the out_last handshake.
- Registers: addr, issue_rem (reads still to issue), beat_rem (beats still to deliver), inflight (1 bit), and a 2-entry skid FIFO.
- Read issue: only in RUN when issue_rem>0 and (fifo_count + inflight − pop) < 2, where pop = out_valid & out_ready. Each issue: addr <= addr + cfg_stride (mod 2^ADDR_W; wrap-around is legal), issue_rem decrements.
- Returning data is pushed into the FIFO the cycle after the issue. The FIFO never overflows; overflow is an assertion failure.
- out_valid = FIFO not empty; out_data = FIFO head. out_last = (beat_rem==1) & out_valid.
- On each pop, beat_rem decrements. On the last pop, done pulses in the next cycle and busy drops in the same cycle as done.
- abort has priority over every other event in any state:
  - next cycle: state IDLE, FIFO empty, counters 0;
  - read data returning from an in-flight read is discarded;
  - no done pulse.
- cfg_valid while not IDLE is ignored.

## Timing
- Reset values: cfg_ready=1 once rst deasserts; all other outputs 0, including mem_rd_addr, out_data and out_last. State is IDLE.
- Handshake at edge T: first mem_rd_en in cycle T+1, first out_valid in cycle T+2.
- Throughput is 1 beat/cycle while out_ready=1. A descriptor of N beats with no stall completes with done in cycle T+N+2.
- out_valid, out_data and out_last hold stable while out_valid & !out_ready.
- Back-to-back: the next descriptor can be accepted in the cycle done is high, because cfg_ready is high there.
- Asynchronous rst mid-descriptor: the descriptor is lost; outputs go to reset values immediately.

## Structure
- dsu_pkg: state enum (IDLE/RUN/DRAIN), LANES/DATA_W defaults, beat-width helper constant.
- Sub-module dsu_skid_fifo: depth 2, width LANES*DATA_W.
  - Ports: push, pop, flush, din, dout, count, empty.
  - Flush clears it synchronously. Reset is asynchronous.

## Test plan
- base=0, len=4, stride=1, out_ready=1, mem[a]=a: beats 0,1,2,3 in consecutive cycles T+2..T+5; out_last on beat 3; done at T+6.
- base=1020, len=6, stride=2, ADDR_W=10: read addresses 1020, 1022, 0, 2, 4, 6 (wrap-around).
- len=8, out_ready toggling 1,0,0,1,...: no lost or duplicated beat, payload stable during stalls, at most 2 beats buffered.
- len=0: no mem_rd_en, no out_valid, done one cycle after the handshake, cfg_ready stays 1.
- abort at beat 3 of 10 with a read in flight: IDLE next cycle, out_valid 0, returning data dropped, no done. A new len=2 descriptor then streams correctly.
- rst asserted mid-stream (asynchronous, between edges): all outputs 0 immediately, cfg_ready=1 once rst deasserts.

Source files
------------

// File: rtl/dsu_pkg.sv
// Shared types and defaults for the data streaming unit.
package dsu_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } dsu_state_e;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefLanes = 4;
  localparam int unsigned DefBeatW = DefDataW * DefLanes;

endpackage

// File: rtl/dsu_skid_fifo.sv
// Two-entry skid FIFO that absorbs read data while the consumer stalls.
module dsu_skid_fifo
  import dsu_pkg::*;
#(
  parameter int unsigned Width = DefBeatW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic [1:0]       count,
  output logic             empty
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;

  // Pointer and occupancy tracking; flush empties the FIFO without touching storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Entry storage; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (push && !flush) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == 2'd0);

  // The issue logic reserves space before reading, so a push into a full FIFO is a bug.
  assert property (@(posedge clk) disable iff (rst) !(push && !pop && !flush && count_q == 2'd2));

endmodule

// File: rtl/dsu_stream.sv
// Descriptor-driven strided reader streaming LANES-wide beats with full backpressure.
module dsu_stream
  import dsu_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned LANES  = DefLanes,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [ADDR_W-1:0]       cfg_base,
  input  logic [LEN_W-1:0]        cfg_len,
  input  logic [ADDR_W-1:0]       cfg_stride,
  input  logic                    abort,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_rd_addr,
  input  logic [LANES*DATA_W-1:0] mem_rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned BeatW = LANES * DATA_W;

  dsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, stride_q, stride_d;
  logic [LEN_W-1:0]  issue_rem_q, issue_rem_d, beat_rem_q, beat_rem_d;
  logic              inflight_q, inflight_d, done_q, done_d;

  logic       cfg_hs, issue, pop, last_issue, last_pop, fifo_empty;
  logic [1:0] fifo_count;
  logic [2:0] occ;

  // Occupancy after this cycle counts the read already in flight, so two slots are never
  // over-committed.
  assign pop        = out_valid & out_ready;
  assign occ        = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue      = (state_q == StRun) && (issue_rem_q != '0) && (occ < 3'd2) && !abort;
  assign cfg_hs     = (state_q == StIdle) && cfg_valid && !abort;
  assign last_issue = issue && (issue_rem_q == LEN_W'(1));
  assign last_pop   = pop && (beat_rem_q == LEN_W'(1));

  assign out_valid   = !fifo_empty;
  assign out_last    = out_valid && (beat_rem_q == LEN_W'(1));
  assign mem_rd_en   = issue;
  assign mem_rd_addr = addr_q;
  assign done        = done_q;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next state; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cfg_hs && cfg_len != '0) state_d = StRun;
      StRun:   if (last_issue) state_d = StDrain;
      StDrain: if (last_pop) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  // FSM outputs.
  always_comb begin
    cfg_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
  end

  // Datapath next state: address walk, remaining counts and completion pulse.
  always_comb begin
    addr_d      = addr_q;
    stride_d    = stride_q;
    issue_rem_d = issue_rem_q;
    beat_rem_d  = beat_rem_q;
    inflight_d  = issue;
    done_d      = 1'b0;
    if (abort) begin
      addr_d      = '0;
      stride_d    = '0;
      issue_rem_d = '0;
      beat_rem_d  = '0;
      inflight_d  = 1'b0;
    end else if (cfg_hs) begin
      addr_d      = cfg_base;
      stride_d    = cfg_stride;
      issue_rem_d = cfg_len;
      beat_rem_d  = cfg_len;
      done_d      = (cfg_len == '0);
    end else begin
      if (issue) begin
        addr_d      = addr_q + stride_q;
        issue_rem_d = issue_rem_q - LEN_W'(1);
      end
      if (pop) begin
        beat_rem_d = beat_rem_q - LEN_W'(1);
        done_d     = last_pop;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      stride_q    <= '0;
      issue_rem_q <= '0;
      beat_rem_q  <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      issue_rem_q <= issue_rem_d;
      beat_rem_q  <= beat_rem_d;
      inflight_q  <= inflight_d;
      done_q      <= done_d;
    end
  end

  // Read data lands one cycle after issue; a cleared inflight flag drops data after abort.
  dsu_skid_fifo #(
    .Width(BeatW)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (inflight_q),
    .pop  (pop),
    .flush(abort),
    .din  (mem_rd_data),
    .dout (out_data),
    .count(fifo_count),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_dsu_stream.sv
// Scoreboard bench for dsu_stream: driver pushes expectations, negedge monitor checks.
module tb_dsu_stream;

  localparam int DW = 16;
  localparam int LN = 4;
  localparam int AW = 10;
  localparam int LW = 10;
  localparam int BW = DW * LN;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0, cfg_ready;
  logic [AW-1:0] cfg_base = '0, cfg_stride = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          abort = 1'b0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [BW-1:0] mem_rd_data = '0;
  logic          out_valid, out_ready = 1'b1, out_last, busy, done;
  logic [BW-1:0] out_data;

  dsu_stream #(
    .DATA_W(DW),
    .LANES (LN),
    .ADDR_W(AW),
    .LEN_W (LW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_base   (cfg_base),
    .cfg_len    (cfg_len),
    .cfg_stride (cfg_stride),
    .abort      (abort),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Lane i of word a holds {i, 2'b00, a} so both address and lane order are visible.
  function automatic logic [BW-1:0] word(input logic [AW-1:0] a);
    logic [BW-1:0] w;
    for (int i = 0; i < LN; i++) w[i*DW +: DW] = {4'(i), 2'b00, a};
    return w;
  endfunction

  // Buffer model with one-cycle read latency.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= word(mem_rd_addr);

  typedef struct packed {
    logic [BW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [AW-1:0] addr_q[$];
  int            n_chk = 0, n_fail = 0, cyc = 0;
  int            done_cnt = 0, done_cyc = -1;
  logic          stall_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Backpressure pattern 1,0,0 repeating.
  always @(posedge clk) begin
    #1;
    if (stall_mode) out_ready = (cyc % 3 == 0);
  end

  // Monitor: compares every read address, every delivered beat and stall stability.
  logic          stall_q = 1'b0, stall_last;
  logic [BW-1:0] stall_data;
  beat_t         mb;
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("stall_valid", BW'(out_valid), BW'(1));
        chk("stall_data", out_data, stall_data);
        chk("stall_last", BW'(out_last), BW'(stall_last));
      end
      if (mem_rd_en) begin
        if (addr_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rd_addr: unexpected read of %0d (cycle %0d)", mem_rd_addr, cyc);
        end else chk("rd_addr", BW'(mem_rd_addr), BW'(addr_q.pop_front()));
      end
      if (out_valid && out_ready && !abort) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL beat: unexpected beat %0h (cycle %0d)", out_data, cyc);
        end else begin
          mb = exp_q.pop_front();
          chk("beat_data", out_data, mb.data);
          chk("beat_last", BW'(out_last), BW'(mb.last));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", BW'(busy), BW'(0));
      end
      stall_q    = out_valid && !out_ready;
      stall_data = out_data;
      stall_last = out_last;
    end
  end

  task automatic expect_seq(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                            input int len);
    logic [AW-1:0] a;
    for (int i = 0; i < len; i++) begin
      a = AW'(base + i * stride);
      addr_q.push_back(a);
      exp_q.push_back({word(a), (i == len - 1)});
    end
  endtask

  // Returns t = cycle index just after the handshake edge.
  task automatic start(input logic [AW-1:0] base, input logic [LW-1:0] len,
                       input logic [AW-1:0] stride, output int t);
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_base = base; cfg_len = len; cfg_stride = stride;
    @(posedge clk); #1;
    t = cyc;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input int cnt0, input string name);
    for (int k = 0; k < 300 && done_cnt == cnt0; k++) begin
      @(negedge clk); #1;
    end
    if (done_cnt == cnt0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: no done pulse within 300 cycles", name);
    end
  endtask

  task automatic check_drained(input string name);
    chk(name, BW'(exp_q.size() + addr_q.size()), BW'(0));
    exp_q.delete();
    addr_q.delete();
  endtask

  logic [AW-1:0] wrap_addr [6] = '{10'd1020, 10'd1022, 10'd0, 10'd2, 10'd4, 10'd6};
  int t, c0;

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_cfg_ready", BW'(cfg_ready), BW'(1));
    chk("rst_busy", BW'(busy), BW'(0));
    chk("rst_out_valid", BW'(out_valid), BW'(0));
    chk("rst_rd_en", BW'(mem_rd_en), BW'(0));
    chk("rst_rd_addr", BW'(mem_rd_addr), BW'(0));
    chk("rst_out_data", out_data, BW'(0));
    chk("rst_out_last", BW'(out_last), BW'(0));
    chk("rst_done", BW'(done), BW'(0));

    // Unit stride, no backpressure: beats at T+2..T+5, done at T+6.
    expect_seq(10'd0, 10'd1, 4);
    c0 = done_cnt;
    start(10'd0, 10'd4, 10'd1, t);
    chk("t1_busy", BW'(busy), BW'(1));
    for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
    chk("t1_first_valid_cyc", BW'(cyc), BW'(t + 2));
    wait_done(c0, "t1_done");
    chk("t1_done_cyc", BW'(done_cyc), BW'(t + 6));
    check_drained("t1_drained");

    // Stride 2 wrapping past the top of the address space.
    foreach (wrap_addr[i]) begin
      addr_q.push_back(wrap_addr[i]);
      exp_q.push_back({word(wrap_addr[i]), (i == 5)});
    end
    c0 = done_cnt;
    start(10'd1020, 10'd6, 10'd2, t);
    wait_done(c0, "t2_done");
    chk("t2_done_cyc", BW'(done_cyc), BW'(t + 8));
    check_drained("t2_drained");

    // Backpressure: payload stable during stalls, nothing lost or duplicated.
    expect_seq(10'd50, 10'd3, 8);
    c0 = done_cnt;
    stall_mode = 1'b1;
    start(10'd50, 10'd8, 10'd3, t);
    wait_done(c0, "t3_done");
    stall_mode = 1'b0;
    out_ready  = 1'b1;
    check_drained("t3_drained");

    // Zero-length descriptor: done in the first cycle after the handshake edge only.
    c0 = done_cnt;
    start(10'd7, 10'd0, 10'd1, t);
    chk("t4_cfg_ready", BW'(cfg_ready), BW'(1));
    wait_done(c0, "t4_done");
    chk("t4_done_cyc", BW'(done_cyc), BW'(t));

    // Abort while beat 3 of 10 is presented and a read is in flight.
    expect_seq(10'd100, 10'd1, 10);
    c0 = done_cnt;
    start(10'd100, 10'd10, 10'd1, t);
    while (cyc < t + 5) begin
      @(posedge clk); #1;
    end
    chk("t5_beat3_data", out_data, word(10'd103));
    abort = 1'b1;
    exp_q.delete();
    addr_q.delete();
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t5_cfg_ready", BW'(cfg_ready), BW'(1));
    chk("t5_busy", BW'(busy), BW'(0));
    chk("t5_out_valid", BW'(out_valid), BW'(0));
    repeat (5) @(posedge clk);
    #1;
    chk("t5_no_done", BW'(done_cnt), BW'(c0));
    expect_seq(10'd200, 10'd5, 2);
    c0 = done_cnt;
    start(10'd200, 10'd2, 10'd5, t);
    wait_done(c0, "t5b_done");
    chk("t5b_done_cyc", BW'(done_cyc), BW'(t + 4));
    check_drained("t5b_drained");

    // Asynchronous reset between edges mid-stream.
    expect_seq(10'd300, 10'd1, 8);
    start(10'd300, 10'd8, 10'd1, t);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t6_out_valid", BW'(out_valid), BW'(0));
    chk("t6_out_data", out_data, BW'(0));
    chk("t6_out_last", BW'(out_last), BW'(0));
    chk("t6_rd_en", BW'(mem_rd_en), BW'(0));
    chk("t6_rd_addr", BW'(mem_rd_addr), BW'(0));
    chk("t6_busy", BW'(busy), BW'(0));
    chk("t6_done", BW'(done), BW'(0));
    exp_q.delete();
    addr_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_cfg_ready", BW'(cfg_ready), BW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
